shift_sequencer: RTL

Multi-position shift controller built around the single-step left/right shifter (dec_LR).
- Accepts an operand, a shift amount and a direction through a start/ready handshake.
- Applies the one-position shifter once per clock until the requested amount is reached, then presents the result with a one-cycle done pulse.
- Sits between the ALU/routing control and the one-step shift datapath, giving variable-distance shifts without a full barrel shifter.

---
 rtl/shift_sequencer_pkg.sv | 15 +
 rtl/shift_sequencer_dec_lr.sv | 31 +++
 rtl/shift_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer.
//   state_t      : controller state encoding (IDLE / SHIFT / DONE)
//   DIR_L, DIR_R : shift direction codes (left = toward MSB, right = toward LSB)
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

endpackage

// File: rtl/shift_sequencer_dec_lr.sv
// dec_LR: single-position left/right shifter with zero fill.
// Ports:
//   din  [WAY-1:0] : operand
//   dir            : DIR_L shifts toward the MSB, DIR_R toward the LSB
//   dout [WAY-1:0] : operand moved by exactly one bit position
module dec_LR
    import shift_sequencer_pkg::*;
#(
    parameter int WAY = 8
) (
    input  logic [WAY-1:0] din,
    input  logic           dir,
    output logic [WAY-1:0] dout
);

    // Each output bit picks its lower or upper neighbour; the end bits
    // take a zero on the side that falls off the word.
    genvar gi;
    generate
        for (gi = 0; gi < WAY; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign dout[gi] = (dir == DIR_R) ? din[gi+1] : 1'b0;
            end else if (gi == WAY - 1) begin : g_msb
                assign dout[gi] = (dir == DIR_R) ? 1'b0 : din[gi-1];
            end else begin : g_mid
                assign dout[gi] = (dir == DIR_R) ? din[gi+1] : din[gi-1];
            end
        end
    endgenerate

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: variable-distance shifter built from a one-step shifter.
// An operation is accepted with start while ready=1; the operand is then moved
// one bit per clock until the requested amount is consumed, after which the
// result is presented for one cycle with done=1 and held until the next done.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : request, sampled only while ready=1
//   data [WAY-1:0]      : operand, captured on accept
//   amt  [AMT_W-1:0]    : number of one-bit steps (0..WAY), captured on accept
//   dir                 : 0 = left, 1 = right (zero fill), captured on accept
//   ready, busy, done   : status; done is a one-cycle pulse
//   result [WAY-1:0]    : last completed shift value
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WAY   = 8,
    parameter int AMT_W = $clog2(WAY) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WAY-1:0]   data,
    input  logic [AMT_W-1:0] amt,
    input  logic             dir,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WAY-1:0]   result
);

    state_t           state_q, state_d;
    logic [WAY-1:0]   sreg_q, sreg_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             dreg_q, dreg_d;
    logic [WAY-1:0]   result_q, result_d;
    logic [WAY-1:0]   shift_out;

    dec_LR #(.WAY(WAY)) u_dec_lr (
        .din  (sreg_q),
        .dir  (dreg_q),
        .dout (shift_out)
    );

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        dreg_d   = dreg_q;
        result_d = result_q;

        case (state_q)
            // DONE accepts a new request exactly like IDLE, which gives
            // back-to-back operation without a dead cycle.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sreg_d = data;
                    cnt_d  = amt;
                    dreg_d = dir;
                    if (amt == '0) begin
                        // Nothing to shift: the operand itself is the result.
                        state_d  = ST_DONE;
                        result_d = data;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                sreg_d = shift_out;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    // Last step: capture the value the shifter produces now,
                    // so result is valid in the done cycle itself.
                    state_d  = ST_DONE;
                    result_d = shift_out;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            dreg_q   <= DIR_L;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            dreg_q   <= dreg_d;
            result_q <= result_d;
        end
    end

    assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule
